// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared framing constants, FSM states and marker detection for the UART TX framer
package uart_frame_pkg;
  localparam logic [7:0] DEF_START_BYTE = 8'h55;
  localparam logic [7:0] DEF_STOP_BYTE = 8'hAA;
  localparam logic [7:0] DEF_ESC_BYTE = 8'h5A;
  localparam logic [7:0] DEF_ESC_XOR = 8'h20;
  typedef enum logic [2:0] {IDLE, START, DATA, ESC2, STOP} state_t;
  function automatic logic is_special(input logic [7:0] b, input logic [7:0] sb, input logic [7:0] pb, input logic [7:0] eb);
    return (b == sb) || (b == pb) || (b == eb);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from pointer+1 with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      pointer,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [GW-1:0]      grant_idx
);
  int idx;
  logic found;
  always_comb begin
    grant_onehot = '0;
    grant_idx = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(pointer) + i) % NUM_REQ;
      if (enable && !found && req[idx]) begin
        found = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx = GW'(idx);
      end
    end
  end
endmodule

// File: rtl/uart_tx_framer_arb.sv
// uart_tx_framer_arb: round-robin shares one byte transmitter, framing each payload
// as START, escaped payload bytes, STOP.
module uart_tx_framer_arb
  import uart_frame_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PAYLOAD_BYTES = 4,
  parameter logic [7:0] START_BYTE = DEF_START_BYTE,
  parameter logic [7:0] STOP_BYTE = DEF_STOP_BYTE,
  parameter logic [7:0] ESC_BYTE = DEF_ESC_BYTE,
  parameter logic [7:0] ESC_XOR = DEF_ESC_XOR,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int W = PAYLOAD_BYTES * 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*W-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [GW-1:0]          grant_id
);
  localparam int CW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  state_t state, state_n;
  logic [W-1:0] shreg, shreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] ptr, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic [7:0] tx_data_n, nb;
  logic hs, adv, last, cur_special;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .pointer(ptr),
    .enable(state == IDLE && rst_n),
    .grant_onehot(gnt),
    .grant_idx(gidx)
  );
  assign req_ack = gnt;
  assign tx_valid = state != IDLE;
  assign busy = tx_valid;
  assign hs = tx_valid && tx_ready;
  assign last = cnt == CW'(PAYLOAD_BYTES - 1);
  assign cur_special = is_special(shreg[7:0], START_BYTE, STOP_BYTE, ESC_BYTE);
  always_comb begin
    state_n = state;
    adv = 1'b0;
    case (state)
      IDLE:  state_n = |gnt ? START : IDLE;
      START: state_n = hs ? DATA : START;
      DATA: begin
        state_n = (hs && cur_special) ? ESC2 : DATA;
        adv = hs && !cur_special;
      end
      ESC2:  adv = hs;
      STOP:  state_n = hs ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    if (adv) state_n = last ? STOP : DATA;
    cnt_n = (state == IDLE) ? '0 : (adv && !last) ? cnt + 1'b1 : cnt;
    shreg_n = |gnt ? req_data[gidx*W +: W] : adv ? shreg >> 8 : shreg;
    nb = shreg_n[7:0];
    // tx_data is computed from the next state so it is registered yet already correct when tx_valid rises
    tx_data_n = (state_n == START) ? START_BYTE :
                (state_n == STOP)  ? STOP_BYTE :
                (state_n == ESC2)  ? nb ^ ESC_XOR :
                (state_n == DATA)  ? (is_special(nb, START_BYTE, STOP_BYTE, ESC_BYTE) ? ESC_BYTE : nb) :
                tx_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      ptr <= GW'(NUM_REQ - 1);
      grant_id <= '0;
      tx_data <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt <= cnt_n;
      tx_data <= tx_data_n;
      if (|gnt) begin
        ptr <= gidx;
        grant_id <= gidx;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_framer_arb.sv
// tb_uart_tx_framer_arb: directed checks of framing, escaping, backpressure, arbitration and reset
module tb_uart_tx_framer_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [63:0] req_data = '0;
  logic [1:0] req_ack;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b1;
  logic busy;
  logic [0:0] grant_id;
  int checks = 0;
  int errors = 0;
  int ack_busy = 0;
  int ack1 = 0;
  int cyc;
  int a1;
  int nv;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_tx_framer_arb dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .grant_id(grant_id)
  );

  always @(negedge clk) begin
    if (busy && req_ack != 2'b00) ack_busy++;
    if (req_ack[1]) ack1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic recv(input string tag);
    cyc = 0;
    for (int k = 0; k < q.size(); k++) begin
      int t = 0;
      while (!(tx_valid && tx_ready) && t < 50) begin
        @(negedge clk);
        t++;
        cyc++;
      end
      chk({tag, "_hs"}, {31'd0, tx_valid && tx_ready}, 32'd1);
      chk({tag, "_byte"}, {24'd0, tx_data}, {24'd0, q[k]});
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant_id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ack", {30'd0, req_ack}, 32'd0);

    req_data[31:0] = 32'h04030201;
    req_valid = 2'b01;
    #1 chk("t1_ack", {30'd0, req_ack}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("t1_ack_drop", {30'd0, req_ack}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    q = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    recv("t1");
    chk("t1_cycles", cyc, 32'd6);
    chk("t1_done", {31'd0, busy}, 32'd0);

    req_data[31:0] = 32'h5AAA5510;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    q = '{8'h55, 8'h10, 8'h5A, 8'h75, 8'h5A, 8'h8A, 8'h5A, 8'h7A, 8'hAA};
    recv("t2");
    chk("t2_cycles", cyc, 32'd9);

    req_data[31:0] = 32'h04030201;
    tx_ready = 1'b0;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_data", {24'd0, tx_data}, 32'h55);
      chk("t3_hold_valid", {31'd0, tx_valid}, 32'd1);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    q = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    recv("t3");
    chk("t3_cycles", cyc, 32'd6);

    reset_dut();
    req_data = {32'h66778899, 32'h11223344};
    req_valid = 2'b11;
    #1;
    for (int f = 0; f < 4; f++) begin
      int t = 0;
      while (req_ack == 2'b00 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("t4_ack", {30'd0, req_ack}, (f % 2) ? 32'd2 : 32'd1);
      @(negedge clk);
      chk("t4_grant", {31'd0, grant_id}, f % 2);
      if (f % 2) q = '{8'h55, 8'h99, 8'h88, 8'h77, 8'h66, 8'hAA};
      else q = '{8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA};
      recv("t4");
    end
    req_valid = 2'b00;
    chk("t4_ack_busy", ack_busy, 32'd0);

    reset_dut();
    req_data[31:0] = 32'h04030201;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    q = '{8'h55, 8'h01, 8'h02};
    recv("t5_pre");
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1 chk("t5_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_ack", {30'd0, req_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t5_ack", {30'd0, req_ack}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("t5_grant", {31'd0, grant_id}, 32'd0);
    q = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    recv("t5");
    chk("t5_cycles", cyc, 32'd6);

    a1 = ack1;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    q = '{8'h02, 8'h03, 8'h04, 8'hAA};
    recv("t6");
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      nv += int'(tx_valid);
    end
    chk("t6_no_frame", nv, 32'd0);
    chk("t6_no_ack1", ack1 - a1, 32'd0);
    chk("t6_ack_busy", ack_busy, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
